lutram_burst_reader: RTL and testbench
======================================

Name: lutram_burst_reader

Overview:
- Read-side controller for the dual-port LUTRAM read port (enb/addrb/doutb, 1-cycle registered read, doutb forced to 0 when enb low).
- Accepts burst read requests (start address, beat count) and issues sequential RAM reads.
- Absorbs the fixed read latency and delivers data as a valid/ready stream with a last flag.
- Holds data in a 2-entry output buffer so downstream backpressure never drops a beat; full throughput of 1 beat/cycle when out_ready stays high.

Parameters:
- DATA_WIDTH, 128, RAM word / stream data width
- ADDR_WIDTH, 8, RAM address width
- LEN_WIDTH, 8, burst length field width; beats = req_len + 1

Ports:
- clk  input  1  clock; all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  burst request valid
- req_ready  output  1  request accepted when req_valid & req_ready
- req_addr  input  ADDR_WIDTH  first word address
- req_len  input  LEN_WIDTH  beats minus one
- ram_enb  output  1  RAM read-port enable
- ram_addrb  output  ADDR_WIDTH  RAM read address
- ram_doutb  input  DATA_WIDTH  RAM read data, valid the cycle after ram_enb
- out_valid  output  1  stream beat valid
- out_ready  input  1  downstream accepts beat
- out_data  output  DATA_WIDTH  beat data
- out_last  output  1  final beat of a burst
- busy  output  1  burst issuing, read in flight, or buffer non-empty

Behaviour:
- Reset (async assert, sync release): state IDLE, buffer empty, in-flight flag 0; req_ready=1 once rst_n high; ram_enb=0, ram_addrb=0, out_valid=0, out_data=0, out_last=0, busy=0.
- States: IDLE, BURST.
- IDLE: req_ready=1, ram_enb=0. On req_valid & req_ready, latch addr and remaining=req_len, go BURST.
- BURST: req_ready=0. Read issued in a cycle when count + inflight - pop < 2. count = buffer occupancy (0..2), inflight = read issued last cycle, pop = out_valid & out_ready.
- Each issue: ram_enb=1, ram_addrb=current addr. Addr increments modulo 2^ADDR_WIDTH (0xFF wraps to 0x00 for ADDR_WIDTH=8). Remaining decrements.
- The issue with remaining==0 is the last. Its in-flight tag carries last=1, and state returns to IDLE the next cycle.
- A new request may be accepted while earlier data drains. Beats stay in order.
- ram_enb is 0 whenever not issuing. ram_addrb holds its last value when idle.
- Capture: when inflight=1, ram_doutb and its last tag are pushed into the buffer at the next edge. Otherwise ram_doutb is ignored, including the zeros it reads when enb is low.
- Latency: request accepted at edge 0. ram_enb high in the following cycle. First beat out_valid after edge 2, so 2 cycles request-to-data.
- Buffer: 2-entry FIFO. out_valid = count>0. out_data/out_last come from the head and are stable while out_valid & !out_ready.
- Simultaneous push and pop: count unchanged. The credit rule guarantees no push when count==2 without a pop.
- out_data=0 and out_last=0 when the buffer is empty.
- busy = (state==BURST) | inflight | (count>0).
- Reset mid-operation: buffer flushed, in-flight read discarded, state IDLE, all outputs at reset values.
- req_len = max (255): 256 beats; the address may wrap.

Test Plan:
- Single beat: req addr=0x10 len=0, out_ready=1 -> ram_enb for 1 cycle, addrb=0x10; one beat with RAM[0x10], out_last=1, 2 cycles after accept; busy low the cycle after the pop.
- 4-beat streaming: addr=0x20 len=3, RAM[i]=i, out_ready=1 -> addrb 0x20..0x23 on consecutive cycles; out_data 0x20..0x23 back-to-back; last only on 0x23.
- Backpressure: addr=0x40 len=7, out_ready low for 5 cycles mid-burst -> ram_enb stops after the buffer fills (≤2 outstanding); no beat lost or duplicated; order 0x40..0x47 preserved.
- Wrap: addr=0xFE len=3 -> addrb FE, FF, 00, 01; data matches RAM at those addresses.
- Back-to-back requests: second request (addr=0x80 len=1) issued immediately after the first burst's last issue -> accepted in IDLE while draining; stream continuous; last asserted once per burst.
- Reset mid-burst: rst_n low during a len=15 burst with 2 beats buffered -> out_valid, ram_enb and busy drop immediately, req_ready=1 after release; a subsequent burst returns correct data with no stale beats.

Source files
------------

// File: rtl/lutram_burst_reader.sv
// lutram_burst_reader: burst read controller for a 1-cycle LUTRAM read port,
// delivering beats through a 2-entry credit-controlled output buffer.
module lutram_burst_reader #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LEN_WIDTH-1:0]  req_len,
    output logic                  ram_enb,
    output logic [ADDR_WIDTH-1:0] ram_addrb,
    input  logic [DATA_WIDTH-1:0] ram_doutb,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy
);
    typedef enum logic {IDLE, BURST} state_t;

    state_t                r_state, w_next;
    logic [ADDR_WIDTH-1:0] r_addr, r_addrb;
    logic [LEN_WIDTH-1:0]  r_rem;
    logic                  r_inflight, r_infl_last;
    logic [DATA_WIDTH:0]   r_mem [2];
    logic                  r_wr, r_rd;
    logic [1:0]            r_count;
    logic                  w_issue, w_pop, w_accept, w_last_issue;

    assign out_valid    = r_count != 2'd0;
    assign w_pop        = out_valid & out_ready;
    assign w_accept     = req_valid & req_ready;
    assign w_last_issue = w_issue & (r_rem == '0);
    assign ram_enb      = w_issue;
    assign ram_addrb    = w_issue ? r_addr : r_addrb;
    assign {out_last, out_data} = out_valid ? r_mem[r_rd] : '0;
    assign busy         = (r_state == BURST) | r_inflight | out_valid;

    // Credit: buffered + in-flight beats may never exceed the two buffer slots.
    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        w_issue   = 1'b0;
        if (r_state == IDLE) begin
            req_ready = 1'b1;
            if (req_valid) w_next = BURST;
        end else begin
            w_issue = ({1'b0, r_count} + {2'b0, r_inflight}) < (3'd2 + {2'b0, w_pop});
            if (w_issue && r_rem == '0) w_next = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_addrb     <= '0;
            r_rem       <= '0;
            r_inflight  <= 1'b0;
            r_infl_last <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_inflight  <= w_issue;
            r_infl_last <= w_last_issue;
            if (w_accept) begin
                r_addr <= req_addr;
                r_rem  <= req_len;
            end else if (w_issue) begin
                r_addr  <= r_addr + 1'b1;
                r_rem   <= r_rem - 1'b1;
                r_addrb <= r_addr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr     <= 1'b0;
            r_rd     <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (r_inflight) begin
                r_mem[r_wr] <= {r_infl_last, ram_doutb};
                r_wr        <= ~r_wr;
            end
            if (w_pop) r_rd <= ~r_rd;
            r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
        end
    end
endmodule

// File: tb/tb_lutram_burst_reader.sv
// tb_lutram_burst_reader: directed plus randomized bursts against a RAM model
// and a queue-based expected-beat scoreboard.
module tb_lutram_burst_reader;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid, req_ready;
    logic [7:0]   req_addr, req_len;
    logic         ram_enb;
    logic [7:0]   ram_addrb;
    logic [127:0] ram_doutb;
    logic         out_valid, out_ready, out_last, busy;
    logic [127:0] out_data;

    logic [127:0] ram [256];
    logic [128:0] exp_q [$];
    logic [7:0]   addr_q [$];
    int           checks = 0, failures = 0, issued = 0, popped = 0;
    bit           rnd_ready = 0;
    logic         prev_stall = 0;
    logic [128:0] prev_beat = '0;

    lutram_burst_reader dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_len(req_len), .ram_enb(ram_enb), .ram_addrb(ram_addrb),
        .ram_doutb(ram_doutb), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ram_doutb <= ram_enb ? ram[ram_addrb] : '0;

    task automatic chk(input string tag, input logic [128:0] got, input logic [128:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every beat a burst should produce is queued at acceptance.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            addr_q.delete();
            issued = 0;
            popped = 0;
            prev_stall = 0;
        end else begin
            chk("outstanding_le2", 129'(issued - popped <= 2), 129'd1);
            if (prev_stall) chk("stall_stable", {out_last, out_data}, prev_beat);
            if (ram_enb) begin
                if (addr_q.size() == 0) chk("spurious_enb", 129'd1, 129'd0);
                else chk("addrb", 129'(ram_addrb), 129'(addr_q.pop_front()));
                issued++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("spurious_beat", {out_last, out_data}, 129'd0);
                else chk("beat", {out_last, out_data}, exp_q.pop_front());
                popped++;
            end
            if (!out_valid) chk("empty_out_zero", {out_last, out_data}, 129'd0);
            if (req_valid && req_ready)
                for (int i = 0; i <= int'(req_len); i++) begin
                    addr_q.push_back(8'(int'(req_addr) + i));
                    exp_q.push_back({i == int'(req_len), ram[8'(int'(req_addr) + i)]});
                end
            prev_stall = out_valid && !out_ready;
            prev_beat  = {out_last, out_data};
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] l);
        int n = 0;
        req_valid = 1'b1;
        req_addr  = a;
        req_len   = l;
        @(negedge clk);
        while (!req_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("req_accept_timeout", 129'(req_ready), 129'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 5000) begin
            cyc(1);
            n++;
        end
        chk("drain_timeout", 129'(exp_q.size() == 0 && !busy), 129'd1);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_len = '0; out_ready = 1'b1;
        for (int i = 0; i < 256; i++) ram[i] = 128'(i);
        cyc(3);
        chk("rst_outs", {out_valid, ram_enb, busy, out_last}, 129'd0);
        chk("rst_data_addr", {out_data, ram_addrb}, 129'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", 129'(req_ready), 129'd1);
        cyc(1);
        // single beat latency
        send(8'h10, 8'd0);
        chk("sb_enb", {ram_enb, ram_addrb, out_valid}, {1'b1, 8'h10, 1'b0});
        cyc(1);
        chk("sb_gap", {ram_enb, out_valid}, 129'd0);
        cyc(1);
        chk("sb_beat", {out_valid, out_last, out_data}, {2'b11, 128'h10});
        cyc(1);
        chk("sb_busy_low", 129'(busy), 129'd0);
        // streaming, backpressure, wrap, back-to-back
        send(8'h20, 8'd3);
        drain();
        send(8'h40, 8'd7);
        cyc(2);
        out_ready = 1'b0;
        cyc(5);
        chk("bp_enb_stopped", 129'(ram_enb), 129'd0);
        out_ready = 1'b1;
        drain();
        send(8'hFE, 8'd3);
        drain();
        send(8'h30, 8'd3);
        send(8'h80, 8'd1);
        drain();
        // reset mid-burst with two beats buffered
        out_ready = 1'b0;
        send(8'h00, 8'd15);
        cyc(4);
        chk("rb_buffered", {out_valid, busy}, 129'd3);
        rst_n = 1'b0;
        #1;
        chk("rb_outs_low", {out_valid, ram_enb, busy}, 129'd0);
        cyc(2);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("rb_req_ready", {req_ready, out_valid}, 129'd2);
        cyc(1);
        send(8'h50, 8'd2);
        drain();
        // randomized bursts with random backpressure
        for (int i = 0; i < 256; i++) ram[i] = {$urandom, $urandom, $urandom, $urandom};
        rnd_ready = 1;
        for (int k = 0; k < 40; k++) begin
            send(8'($urandom), (k == 20) ? 8'd255 : 8'($urandom_range(0, 12)));
            if ($urandom_range(0, 2) == 0) cyc($urandom_range(1, 4));
        end
        drain();
        rnd_ready = 0;
        out_ready = 1'b1;
        cyc(2);
        chk("final_idle", {busy, out_valid, req_ready}, 129'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
